my_regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the Instruction_Decode stage. It adds the following beyond the single-write/two-read file:
- configurable data width, depth, read-port count and write-port count;
- prioritised dual write;
- optional same-cycle write-to-read bypass;
- a sequential clear engine that zeroes every entry after reset or on request, with a ready flag.

Decode reads operands combinationally. Writeback and a second retire path write on the clock edge.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_clr_fsm.sv | 58 +++++
 rtl/my_regfile_mp.sv | 80 ++++++++
 tb/tb_my_regfile_mp.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and clear-engine state encoding for the decode-stage register file.
package regfile_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear engine: sweeps every entry to zero after reset or on request, then flags ready.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              ready_o,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  clr_state_t      state;
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_i) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state   <= ST_RUN;
            ready_o <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + (ADDR_W+1)'(1);
          end
        end
        ST_RUN: begin
          if (clr_i) begin
            state   <= ST_INIT;
            cnt     <= '0;
            ready_o <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          cnt     <= '0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_we   = (state == ST_INIT);
  assign sweep_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/my_regfile_mp.sv
// Multi-port integer register file: prioritised writes, optional same-cycle bypass, sweep clear.
module my_regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     clr_i,
  output logic                     ready_o,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] wa_i,
  input  logic [NUM_WR*DATA_W-1:0] wd_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  output logic [NUM_RD*DATA_W-1:0] rd_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa  [NUM_WR];
  logic [DATA_W-1:0] wd  [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  regfile_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk       (clk),
    .rst_i     (rst_i),
    .clr_i     (clr_i),
    .ready_o   (ready_o),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  // A write is live only in RUN and when it does not target the hardwired zero entry.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k]    = wa_i[k*ADDR_W +: ADDR_W];
    assign wd[k]    = wd_i[k*DATA_W +: DATA_W];
    assign wr_ok[k] = we_i[k] && ready_o && !((ZERO_REG != 0) && (wa[k] == '0));
  end

  // Sweep owns the array during INIT; otherwise higher port index is applied last and wins.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;

    assign a = ra_i[r*ADDR_W +: ADDR_W];

    always_comb begin
      v = mem[a];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_ok[k] && (wa[k] == a)) v = wd[k];
        end
      end
      if (!ready_o || ((ZERO_REG != 0) && (a == '0))) v = '0;
    end

    assign rd_o[r*DATA_W +: DATA_W] = v;
  end

endmodule

// File: tb/tb_my_regfile_mp.sv
// Directed bench for my_regfile_mp: bypassing and non-bypassing instances share one stimulus.
module tb_my_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [1:0]  we  = '0;
  logic [9:0]  wa  = '0;
  logic [63:0] wd  = '0;
  logic [9:0]  ra  = '0;
  logic        ready, ready_nb;
  logic [63:0] rd, rd_nb;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  my_regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_i(rst), .clr_i(clr), .ready_o(ready),
    .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd)
  );

  my_regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst_i(rst), .clr_i(clr), .ready_o(ready_nb),
    .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd_nb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) edge1();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    ra = {5'd3, 5'd1};
    #1;
    chk("rst_rd0", rd[31:0], 32'd0);
    chk("rst_rd1", rd[63:32], 32'd0);

    // Reset release: ready rises on the 32nd edge
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      edge1();
      chk($sformatf("rel_ready_e%0d", e), {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
    end
    chk("rel_ready_nb", {31'd0, ready_nb}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("init_zero_%0d", i), rd[31:0], 32'd0);
      chk($sformatf("init_zero_b%0d", i), rd[63:32], 32'd0);
    end

    // Plain write then read
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF};
    edge1();
    we = 2'b00; ra = {5'd0, 5'd5};
    #1;
    chk("wr5_rd", rd[31:0], 32'hDEADBEEF);
    chk("wr5_rd_nb", rd_nb[31:0], 32'hDEADBEEF);

    // Writes to entry 0 are dropped, including from bypass
    we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h1234, 32'h1234}; ra = {5'd0, 5'd0};
    #1;
    chk("zero_bypass", rd[31:0], 32'd0);
    edge1();
    we = 2'b00;
    #1;
    chk("zero_rd", rd[31:0], 32'd0);
    chk("zero_rd_nb", rd_nb[63:32], 32'd0);

    // Same-address collision: port 1 wins
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h5555, 32'hAAAA}; ra = {5'd5, 5'd7};
    #1;
    chk("coll_bypass", rd[31:0], 32'h5555);
    chk("coll_other_port", rd[63:32], 32'hDEADBEEF);
    edge1();
    we = 2'b00;
    #1;
    chk("coll_rd", rd[31:0], 32'h5555);
    chk("coll_rd_nb", rd_nb[31:0], 32'h5555);

    // Bypass versus pre-edge value
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'hCAFE}; ra = {5'd9, 5'd9};
    #1;
    chk("byp_rd", rd[31:0], 32'hCAFE);
    chk("byp_rd_b", rd[63:32], 32'hCAFE);
    chk("nobyp_rd", rd_nb[31:0], 32'd0);
    edge1();
    we = 2'b00;
    #1;
    chk("nobyp_after", rd_nb[31:0], 32'hCAFE);

    // Fill 1..31, then clear request
    for (int i = 1; i < 32; i++) begin
      we = 2'b01; wa = {5'd0, 5'(i)}; wd = {32'd0, 32'hA500_0000 | 32'(i)};
      edge1();
    end
    we = 2'b00; ra = {5'd31, 5'd17};
    #1;
    chk("fill_17", rd[31:0], 32'hA500_0011);
    chk("fill_31", rd[63:32], 32'hA500_001F);
    clr = 1'b1;
    edge1();
    clr = 1'b0;
    chk("clr_ready_fall", {31'd0, ready}, 32'd0);
    for (int e = 1; e <= 32; e++) begin
      we = (e < 32) ? 2'b11 : 2'b00;
      wa = {5'd20, 5'd3}; wd = {32'hBAD0_0020, 32'hBAD0_0003}; ra = {5'd20, 5'd3};
      #1;
      if (e == 16) begin
        chk("sweep_rd_zero", rd[31:0], 32'd0);
        chk("sweep_rd_zero_b", rd[63:32], 32'd0);
      end
      edge1();
      chk($sformatf("clr_ready_e%0d", e), {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
    end
    we = 2'b00;
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("clr_zero_%0d", i), rd[31:0], 32'd0);
      chk($sformatf("clr_zero_nb%0d", i), rd_nb[63:32], 32'd0);
    end

    // Mid-sweep reset restarts the full sweep after release
    clr = 1'b1;
    edge1();
    clr = 1'b0;
    repeat (10) edge1();
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    repeat (2) edge1();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      edge1();
      chk($sformatf("midrst_ready_e%0d", e), {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
    end
    chk("midrst_ready_nb", {31'd0, ready_nb}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
